// File: rtl/shared_arb_pkg.sv
// Shared types for the shared-slave arbiter.
// FSM state encoding and owner-index width helper.
package shared_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int WDOG_W = 16;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_slave_arbiter_rr_pick.sv
// Circular priority encoder: first set request at or after ptr_i.
// Purely combinational; ptr_i is always below N.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    // Scan offsets from the pointer; the first hit wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!valid_o && req_i[j] && (j == (int'(ptr_i) + i) % N)) begin
                    valid_o = 1'b1;
                    idx_o   = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/shared_slave_arbiter.sv
// Round-robin share of one single-outstanding slave port.
// One transaction in flight, response watchdog, stale-response drop.
module shared_slave_arbiter
    import shared_arb_pkg::*;
#(
    parameter int NB_REQ     = 3,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    localparam int IW        = idx_w(NB_REQ),
    localparam int BW        = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NB_REQ-1:0]            req_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NB_REQ-1:0]            we_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [NB_REQ*BW-1:0]         be_i,
    output logic [NB_REQ-1:0]            gnt_o,
    output logic [NB_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic                         err_o,
    output logic                         s_req_o,
    output logic [ADDR_WIDTH-1:0]        s_addr_o,
    output logic                         s_we_o,
    output logic [DATA_WIDTH-1:0]        s_wdata_o,
    output logic [BW-1:0]                s_be_o,
    input  logic                         s_gnt_i,
    input  logic                         s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]        s_rdata_i,
    input  logic                         s_err_i,
    output logic                         busy_o,
    output logic [IW-1:0]                owner_o
);

    state_e              state_q;
    logic [IW-1:0]       owner_q;
    logic [IW-1:0]       rr_ptr_q;
    logic [WDOG_W-1:0]   wdog_q;
    logic                stale_q;

    logic [IW-1:0]       pick_idx;
    logic                pick_valid;
    logic                resp_ok;
    logic                wdog_hit;
    logic [IW-1:0]       next_ptr_d;

    rr_pick #(
        .N  (NB_REQ),
        .IW (IW)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Response qualification: a real answer beats a simultaneous watchdog expiry.
    always_comb begin
        resp_ok    = (state_q == RESP) && s_rvalid_i && !stale_q;
        wdog_hit   = (state_q == RESP) && !resp_ok &&
                     (wdog_q == WDOG_W'(TIMEOUT - 1));
        next_ptr_d = (owner_q == IW'(NB_REQ - 1)) ? '0 : owner_q + 1'b1;
    end

    // Owner field mux toward the slave and one-hot demux back to requesters.
    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_wdata_o = '0;
        s_be_o    = '0;
        gnt_o     = '0;
        rvalid_o  = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (owner_q == IW'(k)) begin
                if (state_q == ADDR) begin
                    s_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                    s_we_o    = we_i[k];
                    s_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                    s_be_o    = be_i[k*BW +: BW];
                    gnt_o[k]  = s_gnt_i;
                end
                rvalid_o[k] = resp_ok || wdog_hit;
            end
        end
        s_req_o = (state_q == ADDR);
        rdata_o = resp_ok ? s_rdata_i : '0;
        err_o   = resp_ok ? s_err_i : wdog_hit;
        busy_o  = (state_q != IDLE);
        owner_o = owner_q;
    end

    // Transaction FSM with ownership, rotation pointer, watchdog and stale tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
            stale_q  <= 1'b0;
        end else begin
            if (s_rvalid_i && stale_q) begin
                stale_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_gnt_i) begin
                        wdog_q  <= '0;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ok) begin
                        rr_ptr_q <= next_ptr_d;
                        state_q  <= IDLE;
                    end else if (wdog_hit) begin
                        stale_q  <= 1'b1;
                        rr_ptr_q <= next_ptr_d;
                        state_q  <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_slave_arbiter.sv
// Scoreboard bench for shared_slave_arbiter.
// Stimulus pushes expected grants/responses; a negedge monitor pops and checks.
module tb_shared_slave_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_i;
    logic [N*AW-1:0] addr_i;
    logic [N-1:0]    we_i;
    logic [N*DW-1:0] wdata_i;
    logic [N*BW-1:0] be_i;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            err_o;
    logic            s_req_o;
    logic [AW-1:0]   s_addr_o;
    logic            s_we_o;
    logic [DW-1:0]   s_wdata_o;
    logic [BW-1:0]   s_be_o;
    logic            s_gnt_i;
    logic            s_rvalid_i;
    logic [DW-1:0]   s_rdata_i;
    logic            s_err_i;
    logic            busy_o;
    logic [1:0]      owner_o;

    shared_slave_arbiter #(
        .NB_REQ     (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .wdata_i    (wdata_i),
        .be_i       (be_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .s_req_o    (s_req_o),
        .s_addr_o   (s_addr_o),
        .s_we_o     (s_we_o),
        .s_wdata_o  (s_wdata_o),
        .s_be_o     (s_be_o),
        .s_gnt_i    (s_gnt_i),
        .s_rvalid_i (s_rvalid_i),
        .s_rdata_i  (s_rdata_i),
        .s_err_i    (s_err_i),
        .busy_o     (busy_o),
        .owner_o    (owner_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         own;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    int   exp_gnt[$];
    rsp_t exp_rsp[$];
    int   tests = 0;
    int   fails = 0;

    logic [31:0] xaddr [N] = '{32'h1A10_0000, 32'h1A10_0004, 32'h1A10_0008};
    logic        xwe   [N] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] xwdata[N] = '{32'hDA7A_0000, 32'hDA7A_0001, 32'hDA7A_0002};
    logic [3:0]  xbe   [N] = '{4'hF, 4'h3, 4'hC};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every grant or response pulse must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (|gnt_o) begin
                if (exp_gnt.size() == 0) begin
                    chk("gnt_unexpected", 64'(gnt_o), 64'd0);
                end else begin
                    int o;
                    o = exp_gnt.pop_front();
                    chk("gnt_onehot", 64'(gnt_o), 64'(3'b001 << o));
                end
            end
            if (|rvalid_o) begin
                if (exp_rsp.size() == 0) begin
                    chk("rvalid_unexpected", 64'(rvalid_o), 64'd0);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    chk("rvalid_onehot", 64'(rvalid_o), 64'(3'b001 << r.own));
                    chk("rdata", 64'(rdata_o), 64'(r.d));
                    chk("err", 64'(err_o), 64'(r.e));
                end
            end
        end
    end

    // Slave side of one transaction for expected owner own.
    task automatic serve(input int own, input int gdly, input int rdly,
                         input logic [31:0] data, input logic err,
                         input bit silent, input bit abort);
        int n;
        logic [N-1:0] g;
        exp_gnt.push_back(own);
        n = 0;
        while (!s_req_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_req_o) begin
            chk("s_req_o", 64'(s_req_o), 64'd1);
            void'(exp_gnt.pop_back());
            return;
        end
        chk("owner_o", 64'(owner_o), 64'(own));
        chk("s_fields", {s_addr_o, 23'd0, s_we_o, s_wdata_o[3:0], s_be_o},
            {xaddr[own], 23'd0, xwe[own], xwdata[own][3:0], xbe[own]});
        repeat (gdly) begin
            @(posedge clk); #1;
        end
        s_gnt_i = 1'b1;
        #1;
        g = gnt_o;
        @(posedge clk); #1;
        s_gnt_i = 1'b0;
        req_i   = req_i & ~g;
        if (abort) return;
        if (silent) begin
            for (int c = 1; c < 8; c++) begin
                chk("wdog_early", 64'(rvalid_o), 64'd0);
                @(posedge clk); #1;
            end
            exp_rsp.push_back('{own, 32'd0, 1'b1});
            chk("wdog_fire", 64'(rvalid_o), 64'(3'b001 << own));
            @(posedge clk); #1;
            return;
        end
        repeat (rdly) begin
            @(posedge clk); #1;
        end
        s_rvalid_i = 1'b1;
        s_rdata_i  = data;
        s_err_i    = err;
        exp_rsp.push_back('{own, data, err});
        @(posedge clk); #1;
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        s_err_i    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        req_i      = '0;
        addr_i     = {32'h1A10_0008, 32'h1A10_0004, 32'h1A10_0000};
        we_i       = 3'b101;
        wdata_i    = {32'hDA7A_0002, 32'hDA7A_0001, 32'hDA7A_0000};
        be_i       = {4'hC, 4'h3, 4'hF};
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        s_err_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_outs", {gnt_o, rvalid_o, s_req_o, err_o, owner_o}, 64'd0);
        chk("rst_s_addr", 64'(s_addr_o), 64'd0);

        // Single request from requester 1.
        req_i = 3'b010;
        serve(1, 2, 1, 32'h0000_CAFE, 1'b0, 0, 0);

        // Rotation: owner 2, then 0 before 2 again.
        req_i = 3'b100;
        serve(2, 0, 0, 32'h2222_0002, 1'b0, 0, 0);
        req_i = 3'b101;
        serve(0, 1, 0, 32'h3333_0000, 1'b0, 0, 0);
        serve(2, 0, 2, 32'h3333_0002, 1'b0, 0, 0);

        // Contention with pointer at 0.
        req_i = 3'b111;
        serve(0, 0, 0, 32'h1111_0000, 1'b0, 0, 0);
        serve(1, 0, 0, 32'h1111_0001, 1'b0, 0, 0);
        serve(2, 0, 0, 32'h1111_0002, 1'b0, 0, 0);

        // Slave error then clean transaction.
        req_i = 3'b001;
        serve(0, 0, 0, 32'h0BAD_0BAD, 1'b1, 0, 0);
        req_i = 3'b010;
        serve(1, 0, 0, 32'h0000_5A5A, 1'b0, 0, 0);

        // Watchdog, then a late response that must vanish.
        req_i = 3'b100;
        serve(2, 0, 0, 32'h0, 1'b0, 1, 0);
        s_rvalid_i = 1'b1;
        s_rdata_i  = 32'hDEAD_BEEF;
        #1;
        chk("stale_drop", 64'(rvalid_o), 64'd0);
        @(posedge clk); #1;
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        req_i = 3'b001;
        serve(0, 0, 1, 32'h0000_1234, 1'b0, 0, 0);

        // Reset while waiting for a response.
        req_i = 3'b010;
        serve(1, 0, 0, 32'h0, 1'b0, 0, 1);
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_outs", {gnt_o, rvalid_o, s_req_o, err_o, owner_o}, 64'd0);
        chk("arst_rdata", 64'(rdata_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_i = 3'b011;
        serve(0, 0, 0, 32'h0000_00A0, 1'b0, 0, 0);
        serve(1, 0, 0, 32'h0000_00A1, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("gnt_q_left", 64'(exp_gnt.size()), 64'd0);
        chk("rsp_q_left", 64'(exp_rsp.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
